// File: rtl/bsg_fsb_arb_pkg.sv
// bsg_fsb_arb_pkg -- shared types/constants for the FSB node arbiter. Rev 1.0
`default_nettype none

package bsg_fsb_arb_pkg;

  // FSB ring packet: 10 bytes
  localparam int RING_WIDTH_C = 10 * 8;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

`default_nettype wire

// File: rtl/bsg_fsb_node_arbiter_if.sv
// bsg_fsb_node_arbiter_if -- node request / packet output bundle; lock_i exists only with BSG_FSB_ARB_LOCK_EN. Rev 1.0
`default_nettype none

interface bsg_fsb_node_arbiter_if
  import bsg_fsb_arb_pkg::*;
#(
  parameter int nodes_p = 4,
  parameter int width_p = RING_WIDTH_C
);
  localparam int idx_w_lp = $clog2(nodes_p);

  logic [nodes_p-1:0]  en_i;
  logic [nodes_p-1:0]  v_i;
  logic [width_p-1:0]  data_i [nodes_p];
  logic [nodes_p-1:0]  yumi_o;
  logic                v_o;
  logic [width_p-1:0]  data_o;
  logic                ready_i;
  logic [idx_w_lp-1:0] last_grant_o;
`ifdef BSG_FSB_ARB_LOCK_EN
  logic [nodes_p-1:0]  lock_i;
`endif

  modport slave (
`ifdef BSG_FSB_ARB_LOCK_EN
    input  lock_i,
`endif
    input  en_i, v_i, data_i, ready_i,
    output yumi_o, v_o, data_o, last_grant_o
  );

  modport master (
`ifdef BSG_FSB_ARB_LOCK_EN
    output lock_i,
`endif
    output en_i, v_i, data_i, ready_i,
    input  yumi_o, v_o, data_o, last_grant_o
  );

endinterface

`default_nettype wire

// File: rtl/bsg_fsb_rr_pick.sv
// bsg_fsb_rr_pick -- round-robin pick: first set request after ptr, wrapping. Rev 1.0
`default_nettype none

module bsg_fsb_rr_pick #(
  parameter  int nodes_p  = 4,
  localparam int idx_w_lp = $clog2(nodes_p)
) (
  input  logic [nodes_p-1:0]  req_i,
  input  logic [idx_w_lp-1:0] ptr_i,
  output logic [nodes_p-1:0]  grant_o,
  output logic [idx_w_lp-1:0] idx_o,
  output logic                any_o
);

  logic [idx_w_lp-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    // ptr itself is visited last, so the previous winner has lowest priority
    for (int k = 1; k <= nodes_p; k++) begin
      cand = idx_w_lp'((int'(ptr_i) + k) % nodes_p);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bsg_fsb_node_arbiter.sv
// bsg_fsb_node_arbiter -- round-robin FSB node arbiter with one-entry output register. Rev 1.0
// Optional per-node lock enabled by defining BSG_FSB_ARB_LOCK_EN.
`default_nettype none

module bsg_fsb_node_arbiter
  import bsg_fsb_arb_pkg::*;
#(
  parameter int nodes_p = 4,
  parameter int width_p = RING_WIDTH_C
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bsg_fsb_node_arbiter_if.slave bus
);

  localparam int                  idx_w_lp   = $clog2(nodes_p);
  localparam logic [idx_w_lp-1:0] ptr_rst_lp = idx_w_lp'(nodes_p - 1);

  slot_state_e         state_q, state_d;
  logic [idx_w_lp-1:0] ptr_q, ptr_d;
  logic [idx_w_lp-1:0] last_grant_q, last_grant_d;
  logic [width_p-1:0]  data_q, data_d;

  logic [nodes_p-1:0]  req;
  logic [nodes_p-1:0]  pick_grant;
  logic [idx_w_lp-1:0] pick_idx;
  logic                pick_any;
  logic                slot_open;
  logic                do_grant;

`ifdef BSG_FSB_ARB_LOCK_EN
  logic locked_q, locked_d;
  logic lock_hold;

  // The locked node is always ptr_q: it won the locking grant and ptr never moves while locked
  always_comb begin
    lock_hold = locked_q && bus.en_i[ptr_q];
    req       = bus.v_i & bus.en_i;
    if (lock_hold) req = req & (nodes_p'(1) << ptr_q);
    locked_d  = lock_hold;
    if (do_grant) locked_d = bus.lock_i[pick_idx];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) locked_q <= 1'b0;
    else            locked_q <= locked_d;
  end
`else
  assign req = bus.v_i & bus.en_i;
`endif

  bsg_fsb_rr_pick #(.nodes_p(nodes_p)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= EMPTY;
      ptr_q        <= ptr_rst_lp;
      last_grant_q <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (do_grant) state_d = FULL;
      FULL:  if (!do_grant && bus.ready_i) state_d = EMPTY;
    endcase
  end

  // reset_n_i gates yumi so nothing is consumed while reset is held
  always_comb begin
    slot_open        = (state_q == EMPTY) || bus.ready_i;
    do_grant         = reset_n_i && slot_open && pick_any;
    bus.yumi_o       = do_grant ? pick_grant : '0;
    bus.v_o          = (state_q == FULL);
    bus.data_o       = data_q;
    bus.last_grant_o = last_grant_q;
  end

  always_comb begin
    ptr_d        = ptr_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    if (do_grant) begin
      ptr_d        = pick_idx;
      last_grant_d = pick_idx;
      data_d       = bus.data_i[pick_idx];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bsg_fsb_node_arbiter.sv
// tb_bsg_fsb_node_arbiter -- directed and random checks of the FSB node arbiter against a behavioural model. Rev 1.0
`default_nettype none

module tb_bsg_fsb_node_arbiter;

  localparam int N = 4;
  localparam int W = 80;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bsg_fsb_node_arbiter_if #(.nodes_p(N), .width_p(W)) bus ();

  bsg_fsb_node_arbiter #(.nodes_p(N), .width_p(W)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: output slot occupancy, round-robin pointer, held packet
  bit           m_full;
  int           m_ptr;
  int           m_lg;
  logic [W-1:0] m_data;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_ptr  = N - 1;
    m_lg   = 0;
    m_data = '0;
  endtask

  function automatic int ref_pick();
    if (rst_n !== 1'b1) return -1;
    if (m_full && !bus.ready_i) return -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (bus.v_i[c] && bus.en_i[c]) return c;
    end
    return -1;
  endfunction

  task automatic randomize_data();
    logic [95:0] t;
    for (int i = 0; i < N; i++) begin
      t = {$urandom(), $urandom(), $urandom()};
      bus.data_i[i] = t[W-1:0];
    end
  endtask

  // Called just after a falling edge with inputs already applied
  task automatic cycle(input string tag);
    int g;
    #1;
    g = ref_pick();
    chk({tag, ".yumi"}, W'(bus.yumi_o), (g >= 0) ? (W'(1) << g) : W'(0));
    chk({tag, ".v_o"}, W'(bus.v_o), W'(m_full));
    chk({tag, ".last_grant"}, W'(bus.last_grant_o), W'(m_lg));
    if (m_full) chk({tag, ".data_o"}, bus.data_o, m_data);
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      model_reset();
    end else if (g >= 0) begin
      m_full = 1'b1;
      m_data = bus.data_i[g];
      m_lg   = g;
      m_ptr  = g;
    end else if (m_full && bus.ready_i) begin
      m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int seq [5];
    seq = '{0, 1, 2, 3, 0};

    rst_n       = 1'b0;
    bus.v_i     = '1;
    bus.en_i    = '1;
    bus.ready_i = 1'b1;
`ifdef BSG_FSB_ARB_LOCK_EN
    bus.lock_i  = '0;
`endif
    randomize_data();
    model_reset();
    @(negedge clk);

    // Held in reset with every node eligible: nothing may be consumed
    cycle("reset");
    cycle("reset");

    // All nodes valid and enabled, ready high: 0,1,2,3,0 back to back
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      randomize_data();
      cycle("rr_all");
      chk("rr_all.seq", W'(bus.last_grant_o), W'(seq[i]));
      chk("rr_all.v_o", W'(bus.v_o), W'(1));
    end

    // Node 2 valid but disabled
    bus.v_i  = 4'b0101;
    bus.en_i = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      randomize_data();
      cycle("en_mask");
      chk("en_mask.node2_yumi", W'(bus.yumi_o[2]), W'(0));
      chk("en_mask.grant", W'(bus.last_grant_o), W'(0));
    end

    // Stall with the slot full, then drain and refill in one cycle
    bus.v_i  = '1;
    bus.en_i = '1;
    randomize_data();
    cycle("fill");
    bus.ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      randomize_data();
      cycle("stall");
    end
    bus.ready_i = 1'b1;
    randomize_data();
    cycle("drain_refill");
    chk("drain_refill.v_o", W'(bus.v_o), W'(1));

    // Asynchronous reset while full: v_o must drop without a clock edge
    rst_n = 1'b0;
    #1;
    chk("async_rst.v_o", W'(bus.v_o), W'(0));
    chk("async_rst.yumi", W'(bus.yumi_o), W'(0));
    model_reset();
    cycle("in_reset");
    rst_n    = 1'b1;
    bus.v_i  = 4'b1000;
    randomize_data();
    cycle("post_rst");
    chk("post_rst.grant3", W'(bus.last_grant_o), W'(3));
    bus.v_i = '1;
    randomize_data();
    cycle("after_ptr3");
    chk("after_ptr3.grant0", W'(bus.last_grant_o), W'(0));

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      bus.v_i     = N'($urandom());
      bus.en_i    = N'($urandom() | $urandom());
      bus.ready_i = ($urandom_range(0, 3) != 0);
      randomize_data();
      cycle("random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
